// File: rtl/game_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | game_pkg                                                              |
// | Shared screen geometry, default frame period and draw FSM encoding.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package game_pkg;

    // Screen geometry of the VGA adapter (160x120, 3-bit colour)
    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    // 50 MHz system clock / 60 Hz frame rate
    localparam int unsigned FRAME_CYCLES_DEF = 833333;

    // Draw sequencer state encoding
    localparam int unsigned ST_W     = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_START0 = 3'd1;
    localparam logic [2:0]  ST_DRAW0  = 3'd2;
    localparam logic [2:0]  ST_START1 = 3'd3;
    localparam logic [2:0]  ST_DRAW1  = 3'd4;
    localparam logic [2:0]  ST_DONE   = 3'd5;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
    } pixel_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/frame_ticker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_ticker                                                          |
// | Free-running frame counter; tick marks the last cycle of each frame.  |
// | The count is held at zero while enable is low.                        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module frame_ticker
    import game_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear while disabled, wrap at the end of the frame
    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule : frame_ticker
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | draw_scheduler                                                        |
// | Per-frame draw sequencer for two sprite drawers (catcher, square)     |
// | with a registered pixel mux towards the VGA adapter, a per-client     |
// | watchdog and sticky overrun / timeout status.                         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module draw_scheduler
    import game_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES   = FRAME_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [X_W-1:0] c0_x,
    input  logic [Y_W-1:0] c0_y,
    input  logic [C_W-1:0] c0_color,
    input  logic           c0_finish,
    input  logic [X_W-1:0] c1_x,
    input  logic [Y_W-1:0] c1_y,
    input  logic [C_W-1:0] c1_color,
    input  logic           c1_finish,
    output logic           c0_draw,
    output logic           c1_draw,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_color,
    output logic           plot,
    output logic           frame_done,
    output logic           busy,
    output logic           overrun,
    output logic           timeout_err
);

    localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [ST_W-1:0] state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    pixel_t          pix_q;
    logic            plot_q;
    logic            overrun_q;
    logic            timeout_q;

    logic tick;
    logic in_start;
    logic in_draw0;
    logic in_draw1;
    logic wd_expired;
    logic qual0;
    logic qual1;

    frame_ticker #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_ticker (
        .clk_i    (clock),
        .rst_ni   (reset),
        .enable_i (enable),
        .tick_o   (tick)
    );

    assign in_draw0   = (state_q == ST_DRAW0);
    assign in_draw1   = (state_q == ST_DRAW1);
    assign in_start   = (state_q == ST_START0) || (state_q == ST_START1);
    assign wd_expired = (wd_q >= WD_LIMIT);

    // A pixel only counts while the client is drawing, not finishing and not aborted.
    // The START cycles never qualify: the client's outputs are still stale there.
    assign qual0 = in_draw0 && !c0_finish && !wd_expired;
    assign qual1 = in_draw1 && !c1_finish && !wd_expired;

    // Next-state logic of the draw sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick && enable) state_d = ST_START0;
            ST_START0: state_d = ST_DRAW0;
            ST_DRAW0:  if (c0_finish || wd_expired) state_d = ST_START1;
            ST_START1: state_d = ST_DRAW1;
            ST_DRAW1:  if (c1_finish || wd_expired) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Watchdog: restart on entry to a START state, count while a client owns the bus
    always_comb begin
        wd_d = wd_q;
        if ((state_d == ST_START0) || (state_d == ST_START1)) begin
            wd_d = '0;
        end else if (in_start || in_draw0 || in_draw1) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // FSM, watchdog and sticky status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            overrun_q <= overrun_q | (tick && (state_q != ST_IDLE));
            timeout_q <= timeout_q | (wd_expired && (in_draw0 || in_draw1));
        end
    end

    // Pixel mux and output register; vga_* hold their value when nothing is plotted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_q  <= '0;
            plot_q <= 1'b0;
        end else begin
            plot_q <= qual0 || qual1;
            if (qual0) begin
                pix_q <= '{x: c0_x, y: c0_y, color: c0_color};
            end else if (qual1) begin
                pix_q <= '{x: c1_x, y: c1_y, color: c1_color};
            end
        end
    end

    // Draw requests drop combinationally in the cycle finish or the watchdog fires
    assign c0_draw     = (state_q == ST_START0) || qual0;
    assign c1_draw     = (state_q == ST_START1) || qual1;
    assign vga_x       = pix_q.x;
    assign vga_y       = pix_q.y;
    assign vga_color   = pix_q.color;
    assign plot        = plot_q;
    assign frame_done  = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule : draw_scheduler
`default_nettype wire

// File: doc/draw_scheduler.md
# draw_scheduler

Per-frame draw sequencer and pixel multiplexer between the game's sprite drawers and the VGA adapter. On each frame tick it runs a draw/finish handshake with two drawer clients in fixed order: client 0 is the catcher drawer, client 1 is the falling-square drawer. It forwards each active client's pixel stream to the adapter as registered `vga_x`/`vga_y`/`vga_color` with a `plot` strobe, and reports frame completion and overruns.

## Interface
- `FRAME_CYCLES`, default 833333: clock cycles per frame tick (50 MHz / 60 Hz).
- `TIMEOUT_CYCLES`, default 65535: maximum cycles a client may stay in its draw state before it is aborted.
- `clock`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: allow new frames to start.
- `c0_x`, `c1_x`  in  8: client pixel x.
- `c0_y`, `c1_y`  in  7: client pixel y.
- `c0_color`, `c1_color`  in  3: client pixel colour.
- `c0_finish`, `c1_finish`  in  1: client finish_drawing level.
- `c0_draw`, `c1_draw`  out  1: client draw request level.
- `vga_x`  out  8: pixel x to the adapter.
- `vga_y`  out  7: pixel y to the adapter.
- `vga_color`  out  3: pixel colour to the adapter.
- `plot`  out  1: adapter write enable, one pixel per high cycle.
- `frame_done`  out  1: one-cycle pulse after both clients complete.
- `busy`  out  1: high in any state except IDLE.
- `overrun`  out  1: sticky; set when a tick arrives while busy.
- `timeout_err`  out  1: sticky; set when a client is aborted.

## Operation
- Tick counter, width ceil(log2(FRAME_CYCLES)):
  - counts 0..FRAME_CYCLES-1 and wraps;
  - `tick` is high for the cycle in which the count equals FRAME_CYCLES-1;
  - held at 0 while `enable` is low.
- States: IDLE, START0, DRAW0, START1, DRAW1, DONE.
- IDLE -> START0 on `tick` with `enable` high.
- STARTn: `cn_draw`=1. This is a settle cycle: `cn_finish` and the client's pixel outputs are stale, so both are ignored. Always -> DRAWn.
- DRAWn: `cn_draw`=1.
  - A pixel is qualified when `cn_finish`=0.
  - On `cn_finish`=1: drop `cn_draw` in the same cycle. DRAW0 -> START1; DRAW1 -> DONE.
- DONE: pulse `frame_done`, then -> IDLE.
- Watchdog:
  - A per-client cycle counter is cleared on entry to STARTn.
  - When it reaches TIMEOUT_CYCLES in DRAWn, drop `cn_draw`, set `timeout_err`, and advance as if finish had been seen.
- At most one `cn_draw` is high in any cycle. Both are 0 in IDLE and DONE.
- `tick` while busy sets `overrun`. That tick is dropped, not queued.
- `enable` deasserted mid-frame: the current frame completes normally and no new frame starts.
- `overrun` and `timeout_err` clear only on reset.

## Timing
- Reset values of all outputs: 0. Reset also puts the FSM in IDLE, clears the tick counter and clears the watchdog counter.
- `tick` to `c0_draw` high: 1 cycle.
- Pixel path:
  - Registered, latency 1.
  - If client n's pixel is qualified in cycle k, then `vga_*` equal that client's inputs and `plot`=1 in cycle k+1.
  - Otherwise `plot`=0 in cycle k+1 and `vga_*` hold their previous values.
- Finish to the next client's draw: DRAW0 sees `c0_finish` in cycle k; `c0_draw`=0 and `c1_draw`=1 (START1) in cycle k+1.
- Finish to frame completion: `c1_finish` seen in cycle k; `frame_done`=1 in cycle k+1; IDLE in cycle k+2.
- Tick in the same cycle as DONE: counts as overrun, because `busy` is high.
- Asynchronous reset mid-frame: all draws drop immediately; `plot`=0 immediately.

## Structure
- Shared package `game_pkg` holds:
  - the screen width constants (X_W=8, Y_W=7, C_W=3);
  - the FSM state encoding;
  - the default FRAME_CYCLES.
- Sub-module `frame_ticker`: the tick counter with its enable-hold behaviour.
- The FSM, watchdog and pixel mux/register remain in `draw_scheduler`.

## Test plan
All scenarios use FRAME_CYCLES=100 and TIMEOUT_CYCLES=500.
- Tick without enable: `enable`=0 for 300 cycles -> no draw asserted, `busy`=0, all outputs 0.
- Nominal frame:
  - Stimulus: client models are catcher-style; c0 emits 357 pixels, c1 emits 20; the settle cycle presents stale finish=1.
  - Required response: exactly 377 `plot` cycles, with c0 pixels before c1 pixels. `frame_done` pulses once, 1 cycle after `c1_finish` rises.
- Settle-cycle filter:
  - Stimulus: `c0_finish`=1 in START0, then 0 from DRAW0.
  - Required response: no premature advance to START1 and no `plot` from the stale pixel.
- Overrun: c0 takes 150 cycles -> `overrun`=1 after the second tick and exactly one frame completes.
- Timeout: c1 never finishes -> `c1_draw` drops 500 cycles after START1, `timeout_err`=1, `frame_done` pulses.
- Reset mid-DRAW0: `reset` low -> all outputs 0 asynchronously; after release the FSM is in IDLE and the next frame starts only on a fresh tick.
